// File: rtl/xor_verif_pkg.sv
// Shared types and helpers for the xor_design result monitor.
package xor_verif_pkg;

  localparam int unsigned NBINS = 8;

  typedef logic [2:0] bin_t;

  // Top three bits of an operand of width w (3 <= w <= 32), passed zero-extended.
  function automatic bin_t bin_of(input logic [31:0] a, input int unsigned w);
    return bin_t'(a >> (w - 3));
  endfunction

endpackage

// File: rtl/xor_exp_pipe.sv
// LATENCY-deep delay line carrying valid/expected-result/bin alongside xor_design.
module xor_exp_pipe
  import xor_verif_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] exp_d,
  input  logic [2:0]       bin_d,
  output logic             tail_valid,
  output logic [WIDTH-1:0] tail_exp,
  output logic [2:0]       tail_bin
);

  logic [LATENCY-1:0]            vld_q;
  logic [LATENCY-1:0][WIDTH-1:0] exp_q;
  bin_t [LATENCY-1:0]            bin_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      exp_q <= '0;
      bin_q <= '0;
    end else if (clear) begin
      vld_q <= '0;
      exp_q <= '0;
      bin_q <= '0;
    end else begin
      vld_q[0] <= push;
      exp_q[0] <= exp_d;
      bin_q[0] <= bin_d;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        exp_q[i] <= exp_q[i-1];
        bin_q[i] <= bin_q[i-1];
      end
    end
  end

  assign tail_valid = vld_q[LATENCY-1];
  assign tail_exp   = exp_q[LATENCY-1];
  assign tail_bin   = bin_q[LATENCY-1];

endmodule

// File: rtl/xor_result_monitor.sv
// Checker/coverage stage for xor_design: compares y against a delayed a^b,
// counts tests/passes, records operand-A coverage bins and a sticky done flag.
module xor_result_monitor
  import xor_verif_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned NUM_TESTS = 100,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] y,
  output logic             mismatch,
  output logic [WIDTH-1:0] mismatch_exp,
  output logic [CNT_W-1:0] num_tests,
  output logic [CNT_W-1:0] num_pass,
  output logic [NBINS-1:0] cov_bins,
  output logic             cov_full,
  output logic             done
);

  localparam int unsigned ISS_W = $clog2(NUM_TESTS + 1);

  logic [ISS_W-1:0] issued;
  logic             accept;
  logic             tail_valid;
  logic [WIDTH-1:0] tail_exp;
  bin_t             tail_bin;
  logic             hit;
  logic [CNT_W-1:0] tests_nx;
  logic [CNT_W-1:0] pass_nx;
  logic [NBINS-1:0] bins_nx;

  // Issue limit is tracked separately from num_tests so that samples beyond
  // NUM_TESTS are refused even while earlier compares are still in flight.
  assign accept = in_valid && !done && (issued < ISS_W'(NUM_TESTS));

  xor_exp_pipe #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk        (clk),
    .rst_n      (reset),
    .clear      (clear),
    .push       (accept),
    .exp_d      (a ^ b),
    .bin_d      (bin_of(32'(a), WIDTH)),
    .tail_valid (tail_valid),
    .tail_exp   (tail_exp),
    .tail_bin   (tail_bin)
  );

  assign hit = (y == tail_exp);

  always_comb begin
    tests_nx = num_tests;
    pass_nx  = num_pass;
    bins_nx  = cov_bins;
    if (tail_valid) begin
      if (num_tests != '1) tests_nx = num_tests + CNT_W'(1);
      if (hit) begin
        if (num_pass != '1) pass_nx = num_pass + CNT_W'(1);
        bins_nx = cov_bins | (NBINS'(1) << tail_bin);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issued       <= '0;
      mismatch     <= 1'b0;
      mismatch_exp <= '0;
      num_tests    <= '0;
      num_pass     <= '0;
      cov_bins     <= '0;
      cov_full     <= 1'b0;
      done         <= 1'b0;
    end else if (clear) begin
      issued       <= '0;
      mismatch     <= 1'b0;
      mismatch_exp <= '0;
      num_tests    <= '0;
      num_pass     <= '0;
      cov_bins     <= '0;
      cov_full     <= 1'b0;
      done         <= 1'b0;
    end else begin
      if (accept) issued <= issued + ISS_W'(1);
      mismatch <= tail_valid && !hit;
      if (tail_valid && !hit) mismatch_exp <= tail_exp;
      num_tests <= tests_nx;
      num_pass  <= pass_nx;
      cov_bins  <= bins_nx;
      cov_full  <= &bins_nx;
      done      <= done || (tail_valid && (tests_nx == CNT_W'(NUM_TESTS)));
    end
  end

endmodule

// File: tb/tb_xor_result_monitor.sv
// Directed bench for xor_result_monitor: three instances (LATENCY=1, NUM_TESTS=3,
// LATENCY=3) share stimulus; y is produced by bench-side xor_design stand-ins.
module tb_xor_result_monitor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         force_bad = 1'b0;
  logic [W-1:0] y0 = '0;
  logic [W-1:0] d1 = '0, d2 = '0, y2 = '0;

  logic         m0_mis, m1_mis, m2_mis;
  logic [W-1:0] m0_exp, m1_exp, m2_exp;
  logic [15:0]  m0_nt, m1_nt, m2_nt;
  logic [15:0]  m0_np, m1_np, m2_np;
  logic [7:0]   m0_bins, m1_bins, m2_bins;
  logic         m0_full, m1_full, m2_full;
  logic         m0_done, m1_done, m2_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Stand-ins for xor_design at latency 1 (with fault injection) and latency 3.
  always @(posedge clk) begin
    y0 <= (a ^ b) ^ W'(force_bad);
    d1 <= a ^ b;
    d2 <= d1;
    y2 <= d2;
  end

  xor_result_monitor #(.WIDTH(W), .LATENCY(1), .NUM_TESTS(100), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .a(a), .b(b), .y(y0),
    .mismatch(m0_mis), .mismatch_exp(m0_exp), .num_tests(m0_nt), .num_pass(m0_np),
    .cov_bins(m0_bins), .cov_full(m0_full), .done(m0_done));

  xor_result_monitor #(.WIDTH(W), .LATENCY(1), .NUM_TESTS(3), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .a(a), .b(b), .y(y0),
    .mismatch(m1_mis), .mismatch_exp(m1_exp), .num_tests(m1_nt), .num_pass(m1_np),
    .cov_bins(m1_bins), .cov_full(m1_full), .done(m1_done));

  xor_result_monitor #(.WIDTH(W), .LATENCY(3), .NUM_TESTS(100), .CNT_W(16)) u2 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .a(a), .b(b), .y(y2),
    .mismatch(m2_mis), .mismatch_exp(m2_exp), .num_tests(m2_nt), .num_pass(m2_np),
    .cov_bins(m2_bins), .cov_full(m2_full), .done(m2_done));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    check("rst_nt", 32'(m0_nt), 0);
    check("rst_np", 32'(m0_np), 0);
    check("rst_bins", 32'(m0_bins), 0);
    check("rst_full", 32'(m0_full), 0);
    check("rst_done", 32'(m0_done), 0);
    check("rst_mis", 32'(m0_mis), 0);
    reset = 1'b1;
    tick();

    // Single passing compare: 3^5=6, bin a[3:1]=1
    a = 4'd3; b = 4'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t1_mis_a", 32'(m0_mis), 0);
    check("t1_nt_a", 32'(m0_nt), 0);
    tick();
    check("t1_nt", 32'(m0_nt), 1);
    check("t1_np", 32'(m0_np), 1);
    check("t1_bins", 32'(m0_bins), 32'h02);
    check("t1_mis_b", 32'(m0_mis), 0);

    // Forced-bad y on a=4,b=4
    pulse_clear();
    a = 4'd4; b = 4'd4; in_valid = 1'b1; force_bad = 1'b1;
    tick();
    in_valid = 1'b0; force_bad = 1'b0;
    tick();
    check("t2_mis", 32'(m0_mis), 1);
    check("t2_exp", 32'(m0_exp), 0);
    check("t2_nt", 32'(m0_nt), 1);
    check("t2_np", 32'(m0_np), 0);
    check("t2_bins", 32'(m0_bins), 0);
    tick();
    check("t2_mis_once", 32'(m0_mis), 0);

    // Back-to-back coverage sweep a=0,2,..,14
    pulse_clear();
    for (int i = 0; i < 8; i++) begin
      a = W'(2 * i); b = W'(i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("t3_np7", 32'(m0_np), 7);
    check("t3_full7", 32'(m0_full), 0);
    tick();
    check("t3_np8", 32'(m0_np), 8);
    check("t3_bins", 32'(m0_bins), 32'hFF);
    check("t3_full", 32'(m0_full), 1);
    check("t3_mis", 32'(m0_mis), 0);

    // NUM_TESTS=3 limit on u1, five consecutive samples
    pulse_clear();
    for (int i = 1; i <= 5; i++) begin
      a = W'(i); b = 4'd0; in_valid = 1'b1;
      tick();
      if (i == 3) begin
        check("t4_nt2", 32'(m1_nt), 2);
        check("t4_done_lo", 32'(m1_done), 0);
      end
      if (i == 4) begin
        check("t4_nt3", 32'(m1_nt), 3);
        check("t4_done_hi", 32'(m1_done), 1);
      end
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("t4_nt_hold", 32'(m1_nt), 3);
    check("t4_np_hold", 32'(m1_np), 3);
    check("t4_done_hold", 32'(m1_done), 1);
    check("t4_u0_nt5", 32'(m0_nt), 5);

    // LATENCY=3: reset while a sample is in flight
    pulse_clear();
    a = 4'd6; b = 4'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("t5_async_u0nt", 32'(m0_nt), 0);
    check("t5_async_u1done", 32'(m1_done), 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("t5_u2_nt", 32'(m2_nt), 0);
    check("t5_u2_np", 32'(m2_np), 0);
    check("t5_u2_mis", 32'(m2_mis), 0);

    // LATENCY=3 compare timing: 9^3, bin a[3:1]=4
    a = 4'd9; b = 4'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("t6_u2_nt_early", 32'(m2_nt), 0);
    tick();
    check("t6_u2_nt", 32'(m2_nt), 1);
    check("t6_u2_np", 32'(m2_np), 1);
    check("t6_u2_bins", 32'(m2_bins), 32'h10);

    // clear coinciding with a failing compare
    pulse_clear();
    a = 4'd1; b = 4'd1; in_valid = 1'b1;
    tick();
    a = 4'd2; b = 4'd0; force_bad = 1'b1;
    tick();
    in_valid = 1'b0; force_bad = 1'b0;
    check("t7_nt_pre", 32'(m0_nt), 1);
    check("t7_np_pre", 32'(m0_np), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t7_mis", 32'(m0_mis), 0);
    check("t7_nt", 32'(m0_nt), 0);
    check("t7_np", 32'(m0_np), 0);
    check("t7_bins", 32'(m0_bins), 0);
    check("t7_done", 32'(m0_done), 0);
    tick();
    check("t7_mis_after", 32'(m0_mis), 0);
    check("t7_nt_after", 32'(m0_nt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
